r_fetch_unit: RTL
=================

# r_fetch_unit

Instruction fetch stage for the single-cycle R-type CPU, directly upstream of the R-type decoder. Holds the PC, issues one read per instruction to instruction memory over a req/ack handshake, and latches the returned word into the instruction register. Presents the split fields (OP, rs, rt, rd, shamt, func) to the decoder and register file with a valid/ready handshake. Also detects a halt opcode and flags an instruction-memory timeout.

## Interface
Parameters:
- PC_W, 32, PC and memory address width
- RESET_PC, 0, PC value after reset
- MAX_WAIT, 16, maximum cycles in FETCH awaiting imem_ack before bus error (≥2)

Ports (one clock `clk`; reset `rst_n` is synchronous and active-low):
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  run enable; sampled only in IDLE and at hand-off from FULL
- imem_req  out  1  read request, high exactly while state==FETCH
- imem_addr  out  PC_W  read address, equals PC while imem_req high
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word, valid only with imem_ack
- inst_valid  out  1  IR holds an instruction for the decoder
- inst_ready  in  1  decoder/writeback consumes the instruction this cycle
- OP  out  6  IR[31:26]
- rs  out  5  IR[25:21]
- rt  out  5  IR[20:16]
- rd  out  5  IR[15:11]
- shamt  out  5  IR[10:6]
- func  out  6  IR[5:0]
- inst_pc  out  PC_W  address from which IR was fetched
- halted  out  1  halt opcode fetched; sticky until reset
- bus_err  out  1  fetch timed out; sticky until reset

## Operation
- States: IDLE, FETCH, FULL, HALT. All outputs derived from registered state/IR/PC.
- Reset (rst_n low at edge): state=IDLE, PC=RESET_PC, IR=0, inst_pc=0, wait_cnt=0, halted=0, bus_err=0; hence imem_req=0, inst_valid=0, all fields 0.
- IDLE: en=1 → FETCH; else stay.
- FETCH: imem_req=1, imem_addr=PC held stable. wait_cnt increments each cycle without ack.
  - imem_ack with imem_rdata[31:26]==6'b111111 → HALT, halted=1, PC unchanged, IR unchanged, no inst_valid.
  - imem_ack otherwise → IR=imem_rdata, inst_pc=PC, PC=PC+4 (mod 2^PC_W, wraps silently), wait_cnt=0, → FULL.
  - no ack and wait_cnt==MAX_WAIT-1 → HALT, bus_err=1, halted stays 0.
  - en dropping during FETCH does not abort; request completes.
- FULL: inst_valid=1, IR/fields/inst_pc stable until transfer. On inst_ready=1: en=1 → FETCH, en=0 → IDLE. inst_ready=0 → stay.
- HALT: imem_req=0, inst_valid=0; remains until reset. en ignored.
- imem_ack outside FETCH is ignored (no state/IR change).
- Only one request outstanding; no prefetch.

## Timing
- Zero-wait memory (ack in first FETCH cycle): IR and inst_valid visible 1 cycle after FETCH entry; throughput 1 instruction per 2 cycles when inst_ready tied high (FETCH, FULL, FETCH, ...).
- imem_req falls the cycle after the ack cycle; imem_addr changes to PC+4 on that same edge.
- Timeout: with no ack, HALT+bus_err asserted exactly MAX_WAIT cycles after FETCH entry.
- Reset mid-FETCH or mid-FULL: next edge returns all reset values; a concurrent imem_ack is discarded.

## Test plan
- Reset then en=1, memory returns 0x00221820 (add $3,$1,$2) at addr 0 with 0 wait, inst_ready=1 → imem_req at cycle 1, inst_valid at cycle 2 with OP=0, rs=1, rt=2, rd=3, func=6'b100000, inst_pc=0; next imem_addr=4.
- inst_ready held low 5 cycles in FULL → inst_valid and fields stable 5 cycles, imem_req stays 0; on ready, next FETCH at addr+4.
- Ack after 3 wait cycles, MAX_WAIT=16 → imem_addr constant for 4 cycles, instruction latched, no bus_err.
- No ack for 16 cycles → bus_err=1 on 16th cycle edge, imem_req=0 thereafter, halted=0; en toggling has no effect until rst_n low.
- Fetch 0xFC000000 at addr 8 → halted=1, inst_valid never asserted for it, imem_addr frozen at 8.
- PC_W=4, RESET_PC=12: second fetch addresses 0 (wrap); rst_n low during FETCH with simultaneous ack → IDLE, IR=0, PC=12.

Source files
------------

// File: rtl/r_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one word per instruction over a
// req/ack bus, and holds it in the IR for the R-type decoder.
//
// Handshakes:
//   imem: imem_req is high for every FETCH cycle with imem_addr stable. A cycle
//         with imem_ack high completes the read, and imem_rdata is taken only
//         in that cycle. An ack seen outside FETCH is ignored.
//   inst: inst_valid is high while FULL, and the IR fields and inst_pc stay
//         stable. A transfer happens on an edge where inst_valid && inst_ready.
module r_fetch_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [5:0]      OP,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      func,
  output logic [PC_W-1:0] inst_pc,
  output logic            halted,
  output logic            bus_err,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int            WCW       = $clog2(MAX_WAIT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);
  localparam logic [5:0]    HALT_OP   = 6'b111111;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic            halted_q, halted_d;
  logic            bus_err_q, bus_err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_pc_q <= '0;
      ir_q      <= '0;
      wait_q    <= '0;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_pc_q <= inst_pc_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      halted_q  <= halted_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_pc_d = inst_pc_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    halted_d  = halted_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          // A halt word never reaches the IR, so the decoder never sees it.
          if (imem_rdata[31:26] == HALT_OP) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            ir_d      = imem_rdata;
            inst_pc_d = pc_q;
            pc_d      = pc_q + PC_W'(4);
            wait_d    = '0;
            state_d   = S_FULL;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_FULL: begin
        if (inst_ready) begin
          state_d = en ? S_FETCH : S_IDLE;
          wait_d  = '0;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == S_FULL);
  assign OP         = ir_q[31:26];
  assign rs         = ir_q[25:21];
  assign rt         = ir_q[20:16];
  assign rd         = ir_q[15:11];
  assign shamt      = ir_q[10:6];
  assign func       = ir_q[5:0];
  assign inst_pc    = inst_pc_q;
  assign halted     = halted_q;
  assign bus_err    = bus_err_q;
  assign dbg_state  = state_q;

endmodule
